// File: rtl/reglist_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the LDM/STM register-list sequencer.
package reglist_sequencer_pkg;

    localparam int ADDRLEN = 4;
    localparam int LISTLEN = 16;
    localparam int PC_REG  = 15;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_WBACK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [4:0] popcount(input logic [LISTLEN-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < LISTLEN; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/reglist_sequencer_lowest_set_bit.sv
// Priority encoder: index of the lowest set bit of a register list, plus a valid flag.
module lowest_set_bit #(
    parameter int WIDTH = 16,
    parameter int IDXW  = 4
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDXW-1:0]  idx_o,
    output logic             valid_o
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = IDXW'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reglist_sequencer.sv
// Block-transfer (LDM/STM) sequencer: walks a register list lowest-first, one word per
// memory acknowledge, with optional base-register writeback and abort handling.
module reglist_sequencer #(
    parameter int ADDRLEN = reglist_sequencer_pkg::ADDRLEN,
    parameter int LISTLEN = reglist_sequencer_pkg::LISTLEN
) (
    input  logic               sysclk,
    input  logic               nreset,
    input  logic               start,
    input  logic [LISTLEN-1:0] reg_list,
    input  logic               is_load,
    input  logic               writeback,
    input  logic [ADDRLEN-1:0] base_reg,
    input  logic               mem_ack,
    input  logic               abort,
    output logic               busy,
    output logic               mem_req,
    output logic [4:0]         word_idx,
    output logic [4:0]         reg_count,
    output logic [ADDRLEN-1:0] RF_Addr_A,
    output logic [ADDRLEN-1:0] RF_Addr_Write,
    output logic               RF_Load_Write,
    output logic               wb_sel,
    output logic               pc_loaded,
    output logic               done
);

    import reglist_sequencer_pkg::*;

    state_t             state_q;
    logic [LISTLEN-1:0] list_q;
    logic [LISTLEN-1:0] remain_q;
    logic [LISTLEN-1:0] remain_d;
    logic               load_q;
    logic               wb_q;
    logic [ADDRLEN-1:0] base_q;
    logic [4:0]         wordIdx_q;
    logic [4:0]         regCount_q;
    logic               pcLoaded_q;
    logic               aborted_q;

    logic [ADDRLEN-1:0] curIdx;
    logic               curValid;
    logic               inXfer;
    logic               wbNeeded;

    lowest_set_bit #(
        .WIDTH (LISTLEN),
        .IDXW  (ADDRLEN)
    ) u_lsb (
        .vec_i   (remain_q),
        .idx_o   (curIdx),
        .valid_o (curValid)
    );

    assign inXfer   = (state_q == S_XFER) && curValid;
    assign remain_d = remain_q & ~(LISTLEN'(1) << curIdx);
    // A load that overwrites the base register keeps the loaded value, so writeback is dropped.
    assign wbNeeded = wb_q && !(load_q && list_q[base_q]);

    always_ff @(posedge sysclk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= S_IDLE;
            list_q     <= '0;
            remain_q   <= '0;
            load_q     <= 1'b0;
            wb_q       <= 1'b0;
            base_q     <= '0;
            wordIdx_q  <= '0;
            regCount_q <= '0;
            pcLoaded_q <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        list_q     <= reg_list;
                        remain_q   <= reg_list;
                        load_q     <= is_load;
                        wb_q       <= writeback;
                        base_q     <= base_reg;
                        regCount_q <= popcount(reg_list);
                        wordIdx_q  <= '0;
                        pcLoaded_q <= 1'b0;
                        aborted_q  <= 1'b0;
                        state_q    <= (reg_list != '0) ? S_XFER : S_DONE;
                    end
                end
                S_XFER: begin
                    if (abort) begin
                        aborted_q <= 1'b1;
                        state_q   <= S_DONE;
                    end else if (mem_ack && curValid) begin
                        remain_q <= remain_d;
                        if (wordIdx_q != 5'(LISTLEN)) begin
                            wordIdx_q <= wordIdx_q + 5'd1;
                        end
                        if (load_q && (curIdx == ADDRLEN'(PC_REG))) begin
                            pcLoaded_q <= 1'b1;
                        end
                        if (remain_d == '0) begin
                            state_q <= wbNeeded ? S_WBACK : S_DONE;
                        end
                    end
                end
                S_WBACK: begin
                    if (abort) begin
                        aborted_q <= 1'b1;
                    end
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode the registered state; only the write strobe looks at mem_ack/abort.
    always_comb begin
        busy          = (state_q != S_IDLE);
        mem_req       = (state_q == S_XFER);
        word_idx      = wordIdx_q;
        reg_count     = regCount_q;
        RF_Addr_A     = '0;
        RF_Addr_Write = '0;
        RF_Load_Write = 1'b0;
        wb_sel        = 1'b0;
        pc_loaded     = (state_q == S_DONE) && pcLoaded_q && !aborted_q;
        done          = (state_q == S_DONE);
        if (inXfer) begin
            if (load_q) begin
                RF_Addr_Write = curIdx;
                RF_Load_Write = mem_ack && !abort;
            end else begin
                RF_Addr_A = curIdx;
            end
        end else if (state_q == S_WBACK) begin
            RF_Addr_Write = base_q;
            RF_Load_Write = !abort;
            wb_sel        = 1'b1;
        end
    end

endmodule

// File: tb/tb_reglist_sequencer.sv
// Table-driven bench for reglist_sequencer: one vector per clock cycle, plus a reset-mid-transfer sequence.
module tb_reglist_sequencer;

    typedef struct packed {
        logic        start;
        logic [15:0] reg_list;
        logic        is_load;
        logic        writeback;
        logic [3:0]  base_reg;
        logic        mem_ack;
        logic        abort;
    } in_t;

    typedef struct packed {
        logic       busy;
        logic       mem_req;
        logic [4:0] word_idx;
        logic [4:0] reg_count;
        logic [3:0] addr_a;
        logic [3:0] addr_w;
        logic       we;
        logic       wb_sel;
        logic       pc_loaded;
        logic       done;
    } outs_t;

    typedef struct {
        string name;
        in_t   in;
        outs_t exp;
    } vec_t;

    vec_t vecs[$];
    int   vecCount  = 0;
    int   missCount = 0;

    logic        sysclk = 1'b0;
    logic        nreset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] reg_list = '0;
    logic        is_load = 1'b0;
    logic        writeback = 1'b0;
    logic [3:0]  base_reg = '0;
    logic        mem_ack = 1'b0;
    logic        abort = 1'b0;
    logic        busy, mem_req, RF_Load_Write, wb_sel, pc_loaded, done;
    logic [4:0]  word_idx, reg_count;
    logic [3:0]  RF_Addr_A, RF_Addr_Write;

    reglist_sequencer #(.ADDRLEN(4), .LISTLEN(16)) dut (
        .sysclk        (sysclk),
        .nreset        (nreset),
        .start         (start),
        .reg_list      (reg_list),
        .is_load       (is_load),
        .writeback     (writeback),
        .base_reg      (base_reg),
        .mem_ack       (mem_ack),
        .abort         (abort),
        .busy          (busy),
        .mem_req       (mem_req),
        .word_idx      (word_idx),
        .reg_count     (reg_count),
        .RF_Addr_A     (RF_Addr_A),
        .RF_Addr_Write (RF_Addr_Write),
        .RF_Load_Write (RF_Load_Write),
        .wb_sel        (wb_sel),
        .pc_loaded     (pc_loaded),
        .done          (done)
    );

    always #5 sysclk = ~sysclk;

    function automatic in_t mkIn(int st, int rl, int ld, int wb, int br, int ack, int ab);
        in_t i;
        i.start     = 1'(st);
        i.reg_list  = 16'(rl);
        i.is_load   = 1'(ld);
        i.writeback = 1'(wb);
        i.base_reg  = 4'(br);
        i.mem_ack   = 1'(ack);
        i.abort     = 1'(ab);
        return i;
    endfunction

    function automatic outs_t mkOut(int by, int mr, int wi, int rc, int a, int w,
                                    int we, int ws, int pl, int dn);
        outs_t o;
        o.busy      = 1'(by);
        o.mem_req   = 1'(mr);
        o.word_idx  = 5'(wi);
        o.reg_count = 5'(rc);
        o.addr_a    = 4'(a);
        o.addr_w    = 4'(w);
        o.we        = 1'(we);
        o.wb_sel    = 1'(ws);
        o.pc_loaded = 1'(pl);
        o.done      = 1'(dn);
        return o;
    endfunction

    task automatic addVec(input string n, input in_t i, input outs_t e);
        vec_t v;
        v.name = n;
        v.in   = i;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input in_t i);
        start     = i.start;
        reg_list  = i.reg_list;
        is_load   = i.is_load;
        writeback = i.writeback;
        base_reg  = i.base_reg;
        mem_ack   = i.mem_ack;
        abort     = i.abort;
    endtask

    task automatic checkOutput(input string n, input outs_t e);
        outs_t act;
        act = {busy, mem_req, word_idx, reg_count, RF_Addr_A, RF_Addr_Write,
               RF_Load_Write, wb_sel, pc_loaded, done};
        vecCount++;
        if (act !== e) begin
            missCount++;
            $display("[TB] FAIL %s: got busy=%b req=%b idx=%0d cnt=%0d A=%0d W=%0d we=%b wb=%b pc=%b done=%b, expected busy=%b req=%b idx=%0d cnt=%0d A=%0d W=%0d we=%b wb=%b pc=%b done=%b",
                     n, act.busy, act.mem_req, act.word_idx, act.reg_count, act.addr_a, act.addr_w,
                     act.we, act.wb_sel, act.pc_loaded, act.done,
                     e.busy, e.mem_req, e.word_idx, e.reg_count, e.addr_a, e.addr_w,
                     e.we, e.wb_sel, e.pc_loaded, e.done);
        end
    endtask

    initial begin
        // Each row: inputs held across the next rising edge, outputs expected in that same cycle.
        addVec("idle0",          mkIn(0, 0, 0, 0, 0, 0, 0),      mkOut(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        addVec("stm_start",      mkIn(1, 'h000B, 0, 0, 0, 1, 0), mkOut(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        addVec("stm_r0",         mkIn(0, 'h000B, 0, 0, 0, 1, 0), mkOut(1, 1, 0, 3, 0, 0, 0, 0, 0, 0));
        addVec("stm_r1",         mkIn(0, 'h000B, 0, 0, 0, 1, 0), mkOut(1, 1, 1, 3, 1, 0, 0, 0, 0, 0));
        addVec("stm_r3",         mkIn(0, 'h000B, 0, 0, 0, 1, 0), mkOut(1, 1, 2, 3, 3, 0, 0, 0, 0, 0));
        addVec("stm_done",       mkIn(0, 'h000B, 0, 0, 0, 1, 0), mkOut(1, 0, 3, 3, 0, 0, 0, 0, 0, 1));
        addVec("stm_idle",       mkIn(0, 'h000B, 0, 0, 0, 1, 0), mkOut(0, 0, 3, 3, 0, 0, 0, 0, 0, 0));
        addVec("ldm_pc_start",   mkIn(1, 'h8001, 1, 1, 2, 1, 0), mkOut(0, 0, 3, 3, 0, 0, 0, 0, 0, 0));
        addVec("ldm_pc_r0",      mkIn(0, 'h8001, 1, 1, 2, 1, 0), mkOut(1, 1, 0, 2, 0, 0, 1, 0, 0, 0));
        addVec("ldm_pc_r15",     mkIn(0, 'h8001, 1, 1, 2, 1, 0), mkOut(1, 1, 1, 2, 0, 15, 1, 0, 0, 0));
        addVec("ldm_pc_wback",   mkIn(0, 'h8001, 1, 1, 2, 1, 0), mkOut(1, 0, 2, 2, 0, 2, 1, 1, 0, 0));
        addVec("ldm_pc_done",    mkIn(0, 'h8001, 1, 1, 2, 1, 0), mkOut(1, 0, 2, 2, 0, 0, 0, 0, 1, 1));
        addVec("ldm_base_start", mkIn(1, 'h0014, 1, 1, 4, 1, 0), mkOut(0, 0, 2, 2, 0, 0, 0, 0, 0, 0));
        addVec("ldm_base_r2",    mkIn(0, 'h0014, 1, 1, 4, 1, 0), mkOut(1, 1, 0, 2, 0, 2, 1, 0, 0, 0));
        addVec("ldm_base_r4",    mkIn(0, 'h0014, 1, 1, 4, 1, 0), mkOut(1, 1, 1, 2, 0, 4, 1, 0, 0, 0));
        addVec("ldm_base_done",  mkIn(0, 'h0014, 1, 1, 4, 1, 0), mkOut(1, 0, 2, 2, 0, 0, 0, 0, 0, 1));
        addVec("wait_start",     mkIn(1, 'h0003, 1, 0, 0, 0, 0), mkOut(0, 0, 2, 2, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            addVec("wait_hold",  mkIn(0, 'h0003, 1, 0, 0, 0, 0), mkOut(1, 1, 0, 2, 0, 0, 0, 0, 0, 0));
        end
        addVec("wait_ack_r0",    mkIn(0, 'h0003, 1, 0, 0, 1, 0), mkOut(1, 1, 0, 2, 0, 0, 1, 0, 0, 0));
        addVec("wait_r1",        mkIn(0, 'h0003, 1, 0, 0, 1, 0), mkOut(1, 1, 1, 2, 0, 1, 1, 0, 0, 0));
        addVec("wait_done",      mkIn(0, 'h0003, 1, 0, 0, 1, 0), mkOut(1, 0, 2, 2, 0, 0, 0, 0, 0, 1));
        addVec("abort_start",    mkIn(1, 'h00F0, 1, 1, 0, 1, 0), mkOut(0, 0, 2, 2, 0, 0, 0, 0, 0, 0));
        addVec("abort_r4",       mkIn(0, 'h00F0, 1, 1, 0, 1, 0), mkOut(1, 1, 0, 4, 0, 4, 1, 0, 0, 0));
        addVec("abort_r5",       mkIn(0, 'h00F0, 1, 1, 0, 1, 1), mkOut(1, 1, 1, 4, 0, 5, 0, 0, 0, 0));
        addVec("abort_done",     mkIn(0, 'h00F0, 1, 1, 0, 0, 0), mkOut(1, 0, 1, 4, 0, 0, 0, 0, 0, 1));
        addVec("empty_start",    mkIn(1, 'h0000, 1, 1, 3, 1, 0), mkOut(0, 0, 1, 4, 0, 0, 0, 0, 0, 0));
        addVec("empty_done",     mkIn(0, 'h0000, 1, 1, 3, 1, 0), mkOut(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        addVec("empty_idle",     mkIn(0, 'h0000, 1, 1, 3, 1, 0), mkOut(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        addVec("stm_base_start", mkIn(1, 'h0006, 0, 1, 1, 0, 0), mkOut(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        addVec("busy_restart",   mkIn(1, 'hFFFF, 1, 0, 0, 0, 0), mkOut(1, 1, 0, 2, 1, 0, 0, 0, 0, 0));
        addVec("stm_base_r1",    mkIn(0, 'hFFFF, 1, 0, 0, 1, 0), mkOut(1, 1, 0, 2, 1, 0, 0, 0, 0, 0));
        addVec("stm_base_r2",    mkIn(0, 'hFFFF, 1, 0, 0, 1, 0), mkOut(1, 1, 1, 2, 2, 0, 0, 0, 0, 0));
        addVec("stm_base_wback", mkIn(0, 'hFFFF, 1, 0, 0, 1, 0), mkOut(1, 0, 2, 2, 0, 1, 1, 1, 0, 0));
        addVec("stm_base_done",  mkIn(0, 'hFFFF, 1, 0, 0, 1, 0), mkOut(1, 0, 2, 2, 0, 0, 0, 0, 0, 1));
        addVec("stm_base_idle",  mkIn(0, 'hFFFF, 1, 0, 0, 1, 0), mkOut(0, 0, 2, 2, 0, 0, 0, 0, 0, 0));
        addVec("all_start",      mkIn(1, 'hFFFF, 0, 0, 0, 1, 0), mkOut(0, 0, 2, 2, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 16; k++) begin
            addVec("all_word",   mkIn(0, 'hFFFF, 0, 0, 0, 1, 0), mkOut(1, 1, k, 16, k, 0, 0, 0, 0, 0));
        end
        addVec("all_done",       mkIn(0, 'hFFFF, 0, 0, 0, 1, 0), mkOut(1, 0, 16, 16, 0, 0, 0, 0, 0, 1));

        // Reset held with active-looking inputs must still leave every output at zero.
        applyStimulus(mkIn(1, 'h0003, 1, 1, 0, 1, 0));
        nreset = 1'b0;
        repeat (2) @(negedge sysclk);
        #1 checkOutput("reset", '0);
        @(negedge sysclk);
        nreset = 1'b1;
        applyStimulus(mkIn(0, 0, 0, 0, 0, 0, 0));

        foreach (vecs[k]) begin
            @(negedge sysclk);
            applyStimulus(vecs[k].in);
            #1 checkOutput(vecs[k].name, vecs[k].exp);
        end

        // Reset asserted in the middle of a load abandons it immediately.
        @(negedge sysclk);
        applyStimulus(mkIn(1, 'h0003, 1, 1, 0, 0, 0));
        @(negedge sysclk);
        start = 1'b0;
        #1 checkOutput("rst_xfer", mkOut(1, 1, 0, 2, 0, 0, 0, 0, 0, 0));
        #2;
        mem_ack = 1'b1;
        nreset  = 1'b0;
        #1 checkOutput("rst_mid", '0);
        @(negedge sysclk);
        nreset  = 1'b1;
        mem_ack = 1'b0;
        #1 checkOutput("rst_idle", '0);
        @(negedge sysclk);
        #1 checkOutput("rst_stay", '0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/reglist_sequencer.md
REGLIST_SEQUENCER -- requirements
Module: reglist_sequencer

Interface
REQ-001 Parameter ADDRLEN, default 4, register address width.
REQ-002 Parameter LISTLEN, default 16, register-list width (one bit per register r0..r15).
REQ-003 Port sysclk input 1: single clock; all state updates on its rising edge.
REQ-004 Port nreset input 1: asynchronous, active-low reset.
REQ-005 Port start input 1: begin a block transfer (LDM/STM); sampled only in IDLE.
REQ-006 Port reg_list input LISTLEN: registers to transfer; captured with start.
REQ-007 Port is_load input 1: 1 = LDM (memory to register file), 0 = STM; captured with start.
REQ-008 Port writeback input 1: base-register writeback requested; captured with start.
REQ-009 Port base_reg input ADDRLEN: base register number; captured with start.
REQ-010 Port mem_ack input 1: memory accepted/returned the current word this cycle.
REQ-011 Port abort input 1: data abort; terminates the transfer.
REQ-012 Port busy output 1: high in every state except IDLE.
REQ-013 Port mem_req output 1: word transfer requested (XFER state only).
REQ-014 Port word_idx output 5: zero-based index of the current word, for address offset.
REQ-015 Port reg_count output 5: population count of the captured reg_list (0..16).
REQ-016 Port RF_Addr_A output ADDRLEN: register-file read address for the STM source register.
REQ-017 Port RF_Addr_Write output ADDRLEN: register-file write address.
REQ-018 Port RF_Load_Write output 1: register-file write enable.
REQ-019 Port wb_sel output 1: high when the write is base writeback (datapath selects updated base).
REQ-020 Port pc_loaded output 1: pulse in DONE if r15 was loaded by LDM without abort.
REQ-021 Port done output 1: one-cycle completion pulse.

Function
REQ-022 States: IDLE, XFER, WBACK, DONE; encoded state is internal.
REQ-023 IDLE, start=1: capture inputs, compute reg_count, clear word_idx; go XFER if list nonzero, else DONE.
REQ-024 Start while busy is ignored; captured values stay constant until return to IDLE.
REQ-025 XFER: current register is the lowest set bit of the remaining list; drive it on RF_Addr_A (STM) or RF_Addr_Write (LDM).
REQ-026 XFER: mem_req=1 every cycle; transfer completes only in a cycle with mem_ack=1.
REQ-027 LDM: RF_Load_Write=1 combinationally in the mem_ack cycle, wb_sel=0; STM never asserts RF_Load_Write in XFER.
REQ-028 On mem_ack: clear current bit, increment word_idx (width 5, max 16, no wrap).
REQ-029 Ack on the last remaining bit: go WBACK if writeback=1 and not (is_load and base_reg in list), else DONE.
REQ-030 WBACK lasts one cycle: RF_Load_Write=1, RF_Addr_Write=base_reg, wb_sel=1; then DONE.
REQ-031 abort=1 in XFER or WBACK: go DONE next edge, no further writes, no writeback; abort wins over simultaneous mem_ack (no write that cycle).
REQ-032 DONE lasts one cycle: done=1, busy=1; then IDLE.
REQ-033 Empty list: one DONE cycle, no mem_req, no writes, no writeback.
REQ-034 STM with base in list: the original base is stored; writeback occurs normally.

Reset
REQ-035 nreset low: state=IDLE; captured list, base and flags cleared; word_idx=0, reg_count=0.
REQ-036 During reset all outputs are 0; a reset mid-transfer abandons it with no writeback.

Structure
REQ-037 Shared package/header holds ADDRLEN, LISTLEN, the state encoding and PC_REG=15.
REQ-038 One sub-module, lowest_set_bit: 16-bit priority encoder, outputs index and valid.

Verification
REQ-039 STM list 0x000B, writeback=0, mem_ack always 1 -> RF_Addr_A 0,1,3 in consecutive cycles; word_idx 0,1,2; reg_count=3; no writes; done pulse.
REQ-040 LDM list 0x8001, base=2, writeback=1 -> writes r0, r15, then wb_sel write to r2; pc_loaded=1 in DONE.
REQ-041 LDM list 0x0014, base=4, writeback=1 -> writes r2, r4 only; no WBACK cycle.
REQ-042 LDM list 0x0003, mem_ack low 3 cycles then high -> r0 held with mem_req=1 for 4 cycles and written once.
REQ-043 LDM list 0x00F0, abort with second mem_ack -> only r4 written, no writeback, done pulse, pc_loaded=0.
REQ-044 Empty list with start; start pulse while busy; nreset low mid-XFER -> DONE only; start ignored; outputs 0 and IDLE immediately.
